i3c_wrapper: RTL and testbench

I3C_WRAPPER -- requirements
Module: i3c_wrapper

---
 rtl/i3c_pkg.sv | 52 +++++
 rtl/i3c_ahb_if.sv | 101 ++++++++++
 rtl/i3c_wrapper.sv | 215 +++++++++++++++++++++
 tb/tb_i3c_wrapper.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i3c_pkg.sv
// -----------------------------------------------------------------------------
// i3c_pkg
// Shared constants for the I3C wrapper: default DAT/DCT index widths, CSR
// byte offsets, the VERSION value, CONTROL bit positions, the AHB bridge
// state encoding and a byte-strobe merge helper.
// No ports (package).
// -----------------------------------------------------------------------------
package i3c_pkg;

    // Table sizes: each table holds 2**Aw 32-bit words.
    localparam int unsigned DAT_AW_DEFAULT = 5;
    localparam int unsigned DCT_AW_DEFAULT = 5;

    // CSR byte offsets within the 12-bit window.
    localparam logic [11:0] OFF_VERSION  = 12'h000;
    localparam logic [11:0] OFF_CONTROL  = 12'h004;
    localparam logic [11:0] OFF_STATUS   = 12'h008;
    localparam logic [11:0] OFF_RECOVERY = 12'h00C;
    localparam logic [11:0] OFF_SCRATCH  = 12'h010;
    localparam logic [11:0] DAT_BASE     = 12'h400;
    localparam logic [11:0] DCT_BASE     = 12'h800;

    localparam logic [31:0] VERSION_VALUE = 32'h0000_0120;

    // CONTROL layout; reset leaves both lines released while disabled.
    localparam int unsigned CTRL_ENABLE  = 0;
    localparam int unsigned CTRL_SEL_PP  = 1;
    localparam int unsigned CTRL_SCL_OUT = 2;
    localparam int unsigned CTRL_SDA_OUT = 3;
    localparam logic [3:0]  CONTROL_RESET = 4'hC;

    // AHB bridge states.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DATA = 2'd1;
    localparam logic [1:0] ST_ERR1 = 2'd2;
    localparam logic [1:0] ST_ERR2 = 2'd3;

    // Replace only the byte lanes whose strobe bit is set.
    function automatic logic [31:0] apply_strb(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_word;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/i3c_ahb_if.sv
// -----------------------------------------------------------------------------
// i3c_ahb_if
// AHB-Lite slave to simple CSR bridge. Captures the address phase, then in
// the following data phase presents a write strobe (with hwdata/hwstrb
// passed straight through) or returns read data. Any transfer whose size
// is not a 32-bit word gets the two-cycle ERROR response and never reaches
// the CSR side.
// Ports:
//   clk_i, rst_ni                 clock, async active-low reset
//   haddr_i..hready_i             AHB-Lite slave inputs
//   hrdata_o, hreadyout_o, hresp_o AHB-Lite slave outputs
//   csr_addr_o                    byte offset of the data-phase transfer
//   csr_we_o                      write strobe, valid in the data phase
//   csr_wdata_o, csr_wstrb_o      write data / byte enables
//   csr_rdata_i                   read data for csr_addr_o
// -----------------------------------------------------------------------------
module i3c_ahb_if
    import i3c_pkg::*;
#(
    parameter int unsigned AhbDataWidth = 32,
    parameter int unsigned AhbAddrWidth = 32,
    parameter int unsigned CsrAddrWidth = 12
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [AhbAddrWidth-1:0]   haddr_i,
    input  logic [2:0]                hburst_i,
    input  logic [3:0]                hprot_i,
    input  logic [2:0]                hsize_i,
    input  logic [1:0]                htrans_i,
    input  logic [AhbDataWidth-1:0]   hwdata_i,
    input  logic [AhbDataWidth/8-1:0] hwstrb_i,
    input  logic                      hwrite_i,
    input  logic                      hsel_i,
    input  logic                      hready_i,
    output logic [AhbDataWidth-1:0]   hrdata_o,
    output logic                      hreadyout_o,
    output logic                      hresp_o,
    output logic [CsrAddrWidth-1:0]   csr_addr_o,
    output logic                      csr_we_o,
    output logic [AhbDataWidth-1:0]   csr_wdata_o,
    output logic [AhbDataWidth/8-1:0] csr_wstrb_o,
    input  logic [AhbDataWidth-1:0]   csr_rdata_i
);

    logic [1:0]              state_q, state_d;
    logic [CsrAddrWidth-1:0] addr_q;
    logic                    write_q;
    logic                    accept;
    logic                    size_ok;
    logic                    data_rd;

    // Burst type, protection, the SEQ/NONSEQ distinction and the address
    // bits above the CSR window carry no meaning for this slave.
    logic unused_ahb;
    assign unused_ahb = ^{hburst_i, hprot_i, htrans_i[0],
                          haddr_i[AhbAddrWidth-1:CsrAddrWidth]};

    // The first ERROR cycle holds hreadyout low, so no new address phase
    // can legally be taken there.
    assign accept  = hsel_i & hready_i & htrans_i[1] & (state_q != ST_ERR1);
    assign size_ok = (hsize_i == 3'd2);

    // NOTE: every variable assigned in always_comb gets a default first so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = ST_IDLE;
        if (state_q == ST_ERR1) begin
            state_d = ST_ERR2;
        end else if (accept) begin
            state_d = size_ok ? ST_DATA : ST_ERR1;
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept && size_ok) begin
                addr_q  <= haddr_i[CsrAddrWidth-1:0];
                write_q <= hwrite_i;
            end
        end
    end

    assign csr_addr_o  = addr_q;
    assign csr_we_o    = (state_q == ST_DATA) &  write_q;
    assign data_rd     = (state_q == ST_DATA) & ~write_q;
    assign csr_wdata_o = hwdata_i;
    assign csr_wstrb_o = hwstrb_i;

    assign hrdata_o    = data_rd ? csr_rdata_i : '0;
    assign hreadyout_o = (state_q != ST_ERR1);
    assign hresp_o     = (state_q == ST_ERR1) | (state_q == ST_ERR2);

endmodule

// File: rtl/i3c_wrapper.sv
// -----------------------------------------------------------------------------
// i3c_wrapper
// AHB-Lite accessible register front end for an I3C controller: VERSION,
// CONTROL (line drive and OD/PP select), STATUS (synchronized SCL/SDA),
// RECOVERY, SCRATCH and the DAT/DCT tables.
// Optional feature: define I3C_WRAPPER_RECOVERY_EN to implement the RECOVERY
// flag bits and drive the two recovery outputs; otherwise RECOVERY reads 0
// and both outputs are tied low.
// Ports:
//   clk_i, rst_ni                  clock, async active-low reset
//   haddr_i..hready_i              AHB-Lite slave inputs
//   hrdata_o, hreadyout_o, hresp_o AHB-Lite slave outputs
//   scl_i, sda_i                   bus line sense (asynchronous)
//   scl_o, sda_o                   bus line drive, 1 = released
//   sel_od_pp_o                    0 = open-drain, 1 = push-pull
//   recovery_payload_available_o   RECOVERY[0]
//   recovery_image_activated_o     RECOVERY[1]
// -----------------------------------------------------------------------------
module i3c_wrapper
    import i3c_pkg::*;
#(
    parameter int unsigned AhbDataWidth = 32,
    parameter int unsigned AhbAddrWidth = 32,
    parameter int unsigned DatAw        = DAT_AW_DEFAULT,
    parameter int unsigned DctAw        = DCT_AW_DEFAULT,
    parameter int unsigned CsrAddrWidth = 12,
    parameter int unsigned CsrDataWidth = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [AhbAddrWidth-1:0]   haddr_i,
    input  logic [2:0]                hburst_i,
    input  logic [3:0]                hprot_i,
    input  logic [2:0]                hsize_i,
    input  logic [1:0]                htrans_i,
    input  logic [AhbDataWidth-1:0]   hwdata_i,
    input  logic [AhbDataWidth/8-1:0] hwstrb_i,
    input  logic                      hwrite_i,
    output logic [AhbDataWidth-1:0]   hrdata_o,
    output logic                      hreadyout_o,
    output logic                      hresp_o,
    input  logic                      hsel_i,
    input  logic                      hready_i,
    input  logic                      scl_i,
    input  logic                      sda_i,
    output logic                      scl_o,
    output logic                      sda_o,
    output logic                      sel_od_pp_o,
    output logic                      recovery_payload_available_o,
    output logic                      recovery_image_activated_o
);

    logic [CsrAddrWidth-1:0] csr_addr;
    logic                    csr_we;
    logic [CsrDataWidth-1:0] csr_wdata;
    logic [3:0]              csr_wstrb;
    logic [CsrDataWidth-1:0] reg_word;
    logic [CsrDataWidth-1:0] wmerge;
    logic [CsrDataWidth-1:0] rec_word;

    logic [3:0]              control_q;
    logic [CsrDataWidth-1:0] scratch_q;
    logic [CsrDataWidth-1:0] dat_q [2**DatAw];
    logic [CsrDataWidth-1:0] dct_q [2**DctAw];
    logic                    scl_meta_q, scl_sync_q;
    logic                    sda_meta_q, sda_sync_q;

    i3c_ahb_if #(
        .AhbDataWidth (AhbDataWidth),
        .AhbAddrWidth (AhbAddrWidth),
        .CsrAddrWidth (CsrAddrWidth)
    ) u_ahb_if (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .haddr_i     (haddr_i),
        .hburst_i    (hburst_i),
        .hprot_i     (hprot_i),
        .hsize_i     (hsize_i),
        .htrans_i    (htrans_i),
        .hwdata_i    (hwdata_i),
        .hwstrb_i    (hwstrb_i),
        .hwrite_i    (hwrite_i),
        .hsel_i      (hsel_i),
        .hready_i    (hready_i),
        .hrdata_o    (hrdata_o),
        .hreadyout_o (hreadyout_o),
        .hresp_o     (hresp_o),
        .csr_addr_o  (csr_addr),
        .csr_we_o    (csr_we),
        .csr_wdata_o (csr_wdata),
        .csr_wstrb_o (csr_wstrb),
        .csr_rdata_i (reg_word)
    );

    // ---------------------------------------------------------------------
    // Table decode: bits [11:10] select the window, [9:2] the word index.
    // Indices beyond the table size fall through to the read-zero default.
    // ---------------------------------------------------------------------
    logic [7:0]       win_idx;
    logic             word_aligned;
    logic             dat_hit, dct_hit;
    logic [DatAw-1:0] dat_idx;
    logic [DctAw-1:0] dct_idx;

    assign win_idx      = csr_addr[9:2];
    assign word_aligned = (csr_addr[1:0] == 2'b00);
    assign dat_idx      = csr_addr[DatAw+1:2];
    assign dct_idx      = csr_addr[DctAw+1:2];
    assign dat_hit      = word_aligned
                        && (csr_addr[CsrAddrWidth-1:10] == DAT_BASE[CsrAddrWidth-1:10])
                        && (32'(win_idx) < (32'd1 << DatAw));
    assign dct_hit      = word_aligned
                        && (csr_addr[CsrAddrWidth-1:10] == DCT_BASE[CsrAddrWidth-1:10])
                        && (32'(win_idx) < (32'd1 << DctAw));

`ifdef I3C_WRAPPER_RECOVERY_EN
    // Only the two flag bits exist; the rest of RECOVERY reads 0.
    logic [1:0] recovery_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            recovery_q <= 2'b00;
        end else if (csr_we && (csr_addr == CsrAddrWidth'(OFF_RECOVERY))) begin
            recovery_q <= wmerge[1:0];
        end
    end

    assign rec_word                     = {{(CsrDataWidth-2){1'b0}}, recovery_q};
    assign recovery_payload_available_o = recovery_q[0];
    assign recovery_image_activated_o   = recovery_q[1];
`else
    assign rec_word                     = '0;
    assign recovery_payload_available_o = 1'b0;
    assign recovery_image_activated_o   = 1'b0;
`endif

    // Current contents of the addressed word; doubles as the base for
    // partial-strobe writes.
    always_comb begin
        reg_word = '0;
        if (dat_hit) begin
            reg_word = dat_q[dat_idx];
        end else if (dct_hit) begin
            reg_word = dct_q[dct_idx];
        end else begin
            case (csr_addr)
                CsrAddrWidth'(OFF_VERSION):  reg_word = VERSION_VALUE;
                CsrAddrWidth'(OFF_CONTROL):  reg_word = {28'd0, control_q};
                CsrAddrWidth'(OFF_STATUS):   reg_word = {30'd0, sda_sync_q, scl_sync_q};
                CsrAddrWidth'(OFF_RECOVERY): reg_word = rec_word;
                CsrAddrWidth'(OFF_SCRATCH):  reg_word = scratch_q;
                default:                     reg_word = '0;
            endcase
        end
    end

    assign wmerge = apply_strb(reg_word, csr_wdata, csr_wstrb);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            control_q <= CONTROL_RESET;
            scratch_q <= '0;
        end else if (csr_we) begin
            case (csr_addr)
                CsrAddrWidth'(OFF_CONTROL): control_q <= wmerge[3:0];
                CsrAddrWidth'(OFF_SCRATCH): scratch_q <= wmerge;
                default: ;
            endcase
        end
    end

    // NOTE: the tables have a defined reset value of zero, so they are
    // cleared in reset like ordinary registers rather than left as RAM.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 2**DatAw; i++) begin
                dat_q[i] <= '0;
            end
        end else if (csr_we && dat_hit) begin
            dat_q[dat_idx] <= wmerge;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 2**DctAw; i++) begin
                dct_q[i] <= '0;
            end
        end else if (csr_we && dct_hit) begin
            dct_q[dct_idx] <= wmerge;
        end
    end

    // Two-flop synchronizers; reset to the idle (released) line level.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            scl_meta_q <= 1'b1;
            scl_sync_q <= 1'b1;
            sda_meta_q <= 1'b1;
            sda_sync_q <= 1'b1;
        end else begin
            scl_meta_q <= scl_i;
            scl_sync_q <= scl_meta_q;
            sda_meta_q <= sda_i;
            sda_sync_q <= sda_meta_q;
        end
    end

    // Line drive follows CONTROL directly; a disabled controller releases
    // both lines and stays open-drain.
    assign scl_o       = control_q[CTRL_ENABLE] ? control_q[CTRL_SCL_OUT] : 1'b1;
    assign sda_o       = control_q[CTRL_ENABLE] ? control_q[CTRL_SDA_OUT] : 1'b1;
    assign sel_od_pp_o = control_q[CTRL_ENABLE] & control_q[CTRL_SEL_PP];

endmodule

// File: tb/tb_i3c_wrapper.sv
// -----------------------------------------------------------------------------
// tb_i3c_wrapper
// Directed self-checking bench for i3c_wrapper. Inputs are driven on the
// falling clock edge and outputs sampled 1 ns later. Honours
// I3C_WRAPPER_RECOVERY_EN for the recovery expectations.
// -----------------------------------------------------------------------------
module tb_i3c_wrapper;

`ifdef I3C_WRAPPER_RECOVERY_EN
    localparam logic REC_EN = 1'b1;
`else
    localparam logic REC_EN = 1'b0;
`endif

    logic        clk_i;
    logic        rst_ni;
    logic [31:0] haddr_i;
    logic [2:0]  hburst_i;
    logic [3:0]  hprot_i;
    logic [2:0]  hsize_i;
    logic [1:0]  htrans_i;
    logic [31:0] hwdata_i;
    logic [3:0]  hwstrb_i;
    logic        hwrite_i;
    logic [31:0] hrdata_o;
    logic        hreadyout_o;
    logic        hresp_o;
    logic        hsel_i;
    wire         hready_i;
    logic        scl_i;
    logic        sda_i;
    logic        scl_o;
    logic        sda_o;
    logic        sel_od_pp_o;
    logic        recovery_payload_available_o;
    logic        recovery_image_activated_o;

    // Single-slave bus: the slave's own ready closes the loop.
    assign hready_i = hreadyout_o;

    i3c_wrapper dut (
        .clk_i                        (clk_i),
        .rst_ni                       (rst_ni),
        .haddr_i                      (haddr_i),
        .hburst_i                     (hburst_i),
        .hprot_i                      (hprot_i),
        .hsize_i                      (hsize_i),
        .htrans_i                     (htrans_i),
        .hwdata_i                     (hwdata_i),
        .hwstrb_i                     (hwstrb_i),
        .hwrite_i                     (hwrite_i),
        .hrdata_o                     (hrdata_o),
        .hreadyout_o                  (hreadyout_o),
        .hresp_o                      (hresp_o),
        .hsel_i                       (hsel_i),
        .hready_i                     (hready_i),
        .scl_i                        (scl_i),
        .sda_i                        (sda_i),
        .scl_o                        (scl_o),
        .sda_o                        (sda_o),
        .sel_od_pp_o                  (sel_od_pp_o),
        .recovery_payload_available_o (recovery_payload_available_o),
        .recovery_image_activated_o   (recovery_image_activated_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    // Results of the most recent transfer.
    logic [31:0] r_data;
    logic        r_resp;
    logic        r_rdy1;
    logic        r_resp1;
    int          r_waits;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One transfer: address phase on one falling edge, data phase on the
    // next; waits for hreadyout for at most 8 cycles.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                        input logic [31:0] wdata, input logic [3:0] strb);
        @(negedge clk_i);
        hsel_i   = 1'b1;
        htrans_i = 2'b10;
        haddr_i  = addr;
        hwrite_i = wr;
        hsize_i  = size;
        @(negedge clk_i);
        hsel_i   = 1'b0;
        htrans_i = 2'b00;
        hwdata_i = wdata;
        hwstrb_i = strb;
        #1;
        r_rdy1  = hreadyout_o;
        r_resp1 = hresp_o;
        r_waits = 0;
        while (hreadyout_o !== 1'b1 && r_waits < 8) begin
            @(negedge clk_i);
            #1;
            r_waits++;
        end
        r_data = hrdata_o;
        r_resp = hresp_o;
    endtask

    task automatic rd(input logic [31:0] addr);
        xfer(1'b0, addr, 3'd2, 32'h0, 4'h0);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        xfer(1'b1, addr, 3'd2, data, strb);
    endtask

    // Let the write's data phase commit, then sample.
    task automatic settle();
        @(negedge clk_i);
        #1;
    endtask

    initial begin
        rst_ni   = 1'b0;
        haddr_i  = '0;
        hburst_i = '0;
        hprot_i  = '0;
        hsize_i  = 3'd2;
        htrans_i = 2'b00;
        hwdata_i = '0;
        hwstrb_i = '0;
        hwrite_i = 1'b0;
        hsel_i   = 1'b0;
        scl_i    = 1'b1;
        sda_i    = 1'b1;

        // ---- reset state ----
        repeat (3) @(negedge clk_i);
        #1;
        check("rst_hreadyout", 32'(hreadyout_o), 32'd1);
        check("rst_hresp",     32'(hresp_o),     32'd0);
        check("rst_hrdata",    hrdata_o,         32'h0);
        check("rst_scl_o",     32'(scl_o),       32'd1);
        check("rst_sda_o",     32'(sda_o),       32'd1);
        check("rst_sel_od_pp", 32'(sel_od_pp_o), 32'd0);
        check("rst_rec_pay",   32'(recovery_payload_available_o), 32'd0);
        check("rst_rec_img",   32'(recovery_image_activated_o),   32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // ---- VERSION / CONTROL reset values ----
        rd(32'h000);
        check("version_data",  r_data,          32'h0000_0120);
        check("version_resp",  32'(r_resp),     32'd0);
        check("version_waits", 32'(r_waits),    32'd0);
        rd(32'h004);
        check("control_reset", r_data,          32'h0000_000C);

        // ---- CONTROL drives lines ----
        wr(32'h004, 32'h0000_0003, 4'hF);
        settle();
        check("ctl3_sel_od_pp", 32'(sel_od_pp_o), 32'd1);
        check("ctl3_scl_o",     32'(scl_o),       32'd0);
        check("ctl3_sda_o",     32'(sda_o),       32'd0);
        wr(32'h004, 32'h0000_0002, 4'hF);
        settle();
        check("ctl2_sel_od_pp", 32'(sel_od_pp_o), 32'd0);
        check("ctl2_scl_o",     32'(scl_o),       32'd1);
        check("ctl2_sda_o",     32'(sda_o),       32'd1);
        wr(32'h004, 32'hFFFF_FFF0, 4'hF);
        rd(32'h004);
        check("control_upper_zero", r_data, 32'h0000_0000);

        // ---- STATUS synchronizer latency ----
        @(negedge clk_i);
        sda_i    = 1'b0;
        hsel_i   = 1'b1;
        htrans_i = 2'b10;
        haddr_i  = 32'h008;
        hwrite_i = 1'b0;
        hsize_i  = 3'd2;
        @(negedge clk_i);
        hsel_i   = 1'b0;
        htrans_i = 2'b00;
        #1;
        check("status_1st_cycle", hrdata_o, 32'h0000_0003);
        rd(32'h008);
        check("status_sda_low", r_data, 32'h0000_0001);
        sda_i = 1'b1;

        // ---- byte strobes / tables ----
        wr(32'h010, 32'hDEAD_BEEF, 4'h3);
        rd(32'h010);
        check("scratch_strb", r_data, 32'h0000_BEEF);
        wr(32'h47C, 32'h1234_5678, 4'hF);
        rd(32'h47C);
        check("dat31", r_data, 32'h1234_5678);
        wr(32'h814, 32'hA5A5_0F0F, 4'hF);
        rd(32'h814);
        check("dct5", r_data, 32'hA5A5_0F0F);

        // ---- out of range / unmapped / read-only ----
        wr(32'h480, 32'hFFFF_FFFF, 4'hF);
        check("dat_oor_wr_resp", 32'(r_resp), 32'd0);
        rd(32'h480);
        check("dat_oor_read", r_data, 32'h0);
        rd(32'h400);
        check("dat0_untouched", r_data, 32'h0);
        rd(32'h014);
        check("unmapped_read", r_data, 32'h0);
        wr(32'h000, 32'hFFFF_FFFF, 4'hF);
        rd(32'h000);
        check("version_ro", r_data, 32'h0000_0120);

        // ---- size error ----
        xfer(1'b0, 32'h010, 3'd1, 32'h0, 4'h0);
        check("err_c1_ready", 32'(r_rdy1),  32'd0);
        check("err_c1_resp",  32'(r_resp1), 32'd1);
        check("err_waits",    32'(r_waits), 32'd1);
        check("err_c2_resp",  32'(r_resp),  32'd1);
        xfer(1'b1, 32'h010, 3'd1, 32'h1111_1111, 4'hF);
        check("err_wr_resp", 32'(r_resp), 32'd1);
        rd(32'h010);
        check("err_no_update", r_data, 32'h0000_BEEF);

        // ---- read directly after write to same address ----
        @(negedge clk_i);
        hsel_i   = 1'b1;
        htrans_i = 2'b10;
        haddr_i  = 32'h010;
        hwrite_i = 1'b1;
        hsize_i  = 3'd2;
        @(negedge clk_i);
        hwdata_i = 32'hCAFE_F00D;
        hwstrb_i = 4'hF;
        hwrite_i = 1'b0;
        @(negedge clk_i);
        hsel_i   = 1'b0;
        htrans_i = 2'b00;
        #1;
        check("raw_data",  hrdata_o,         32'hCAFE_F00D);
        check("raw_ready", 32'(hreadyout_o), 32'd1);
        settle();
        check("idle_hrdata_zero", hrdata_o, 32'h0);

        // ---- recovery ----
        wr(32'h00C, 32'h0000_0003, 4'hF);
        settle();
        check("rec_payload", 32'(recovery_payload_available_o), 32'(REC_EN));
        check("rec_image",   32'(recovery_image_activated_o),   32'(REC_EN));
        rd(32'h00C);
        check("rec_readback", r_data, REC_EN ? 32'h3 : 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
